// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// opcode constants and instruction-register field positions.
package fetch_pkg;

  // Fetch controller states
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fetch_state_e;

  // Opcodes carried in ir[3:0]
  localparam logic [3:0] OP_ADD   = 4'b0100;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_NAND  = 4'b1000;
  localparam logic [3:0] OP_LOAD  = 4'b0000;
  localparam logic [3:0] OP_STORE = 4'b0010;
  localparam logic [3:0] OP_BPZ   = 4'b1101;
  localparam logic [3:0] OP_BZ    = 4'b0101;
  localparam logic [3:0] OP_BNZ   = 4'b1001;
  localparam logic [3:0] OP_JR    = 4'b1110;
  localparam logic [3:0] OP_JAL   = 4'b1100;
  localparam logic [3:0] OP_LDIND = 4'b0001;

  // Instruction-register field bit positions
  localparam int INSTR_MSB = 3;
  localparam int INSTR_LSB = 0;
  localparam int R1_MSB    = 7;
  localparam int R1_LSB    = 6;
  localparam int R2_MSB    = 5;
  localparam int R2_LSB    = 4;
  localparam int IMM4_MSB  = 7;
  localparam int IMM4_LSB  = 4;
  localparam int IMM3_MSB  = 5;
  localparam int IMM3_LSB  = 3;
  localparam int IMM5_MSB  = 7;
  localparam int IMM5_LSB  = 3;

endpackage

// File: rtl/ir_field_decode.sv
// Combinational split of the 8-bit instruction register into opcode and
// operand fields. Shared with the disassembly monitor.
module ir_field_decode
  import fetch_pkg::*;
(
  input  logic [7:0] ir_i,
  output logic [3:0] instr_o,
  output logic [1:0] r1_o,
  output logic [1:0] r2_o,
  output logic [3:0] imm4_o,
  output logic [2:0] imm3_o,
  output logic [4:0] imm5_o
);

  // Pure wiring; fields overlap by design
  always_comb begin
    instr_o = ir_i[INSTR_MSB:INSTR_LSB];
    r1_o    = ir_i[R1_MSB:R1_LSB];
    r2_o    = ir_i[R2_MSB:R2_LSB];
    imm4_o  = ir_i[IMM4_MSB:IMM4_LSB];
    imm3_o  = ir_i[IMM3_MSB:IMM3_LSB];
    imm5_o  = ir_i[IMM5_MSB:IMM5_LSB];
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch + IR stage ahead of the multicycle control FSM.
// Runs a req/ack read on instruction memory, stalls the FSM until the word
// lands in IR, and presents decoded fields.
// Optional feature macro: FETCH_TIMEOUT_EN (abort a stuck read after
// TIMEOUT_CYC ack-less BUSY cycles, load TIMEOUT_INSTR, set sticky bus_err).
//
// Handshake: mem_req rises on the accept edge and stays high, with mem_addr
// stable, until the edge on which mem_ack=1 is sampled; mem_rdata is only
// sampled on that edge. mem_ack outside BUSY is ignored.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int              DATA_W        = 8,
  parameter int              ADDR_W        = 8,
  parameter int              TIMEOUT_CYC   = 15,
  parameter logic [DATA_W-1:0] TIMEOUT_INSTR = 8'b0000_1010
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic [DATA_W-1:0] ir,
  output logic              ir_valid,
  output logic [3:0]        instr,
  output logic [1:0]        r1,
  output logic [1:0]        r2,
  output logic [3:0]        imm4,
  output logic [2:0]        imm3,
  output logic [4:0]        imm5,
  output logic              bus_err
);

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`else
  // Timeout parameters have no effect without the timeout feature
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{TIMEOUT_INSTR, TIMEOUT_CYC[0]};
`endif

  // Next-state and registered-output logic for the IDLE/BUSY controller
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    ir_d       = ir_q;
    ir_valid_d = ir_valid_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d      = cnt_q;
    bus_err_d  = bus_err_q;
`endif
    case (state_q)
      IDLE: begin
        if (fetch_req) begin
          state_d    = BUSY;
          mem_addr_d = fetch_addr;
          mem_req_d  = 1'b1;
          ir_valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
          cnt_d      = '0;
`endif
        end
      end
      BUSY: begin
        if (mem_ack) begin
          // Ack wins over a coincident timeout
          state_d    = IDLE;
          ir_d       = mem_rdata;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          ir_d       = TIMEOUT_INSTR;
          ir_valid_d = 1'b1;
          mem_req_d  = 1'b0;
          bus_err_d  = 1'b1;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, async active-low reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Wait counter and sticky bus error
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Hold the control FSM while a fetch is pending or being accepted;
  // forced low while reset is asserted.
  assign stall = reset_n & ((state_q == BUSY) | ((state_q == IDLE) & fetch_req));

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign ir       = ir_q;
  assign ir_valid = ir_valid_q;

  ir_field_decode u_decode (
    .ir_i    (ir_q[7:0]),
    .instr_o (instr),
    .r1_o    (r1),
    .r2_o    (r2),
    .imm4_o  (imm4),
    .imm3_o  (imm3),
    .imm5_o  (imm5)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + lightly randomised bench for instr_fetch_unit.
// Build with +define+FETCH_TIMEOUT_EN to exercise the timeout path.
module tb_instr_fetch_unit;

  logic       clock;
  logic       reset_n;
  logic       fetch_req;
  logic [7:0] fetch_addr;
  logic       mem_req;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_ack;
  logic       stall;
  logic [7:0] ir;
  logic       ir_valid;
  logic [3:0] instr;
  logic [1:0] r1;
  logic [1:0] r2;
  logic [3:0] imm4;
  logic [2:0] imm3;
  logic [4:0] imm5;
  logic       bus_err;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  logic       prev_valid = 1'b0;

  instr_fetch_unit dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .stall      (stall),
    .ir         (ir),
    .ir_valid   (ir_valid),
    .instr      (instr),
    .r1         (r1),
    .r2         (r2),
    .imm4       (imm4),
    .imm3       (imm3),
    .imm5       (imm5),
    .bus_err    (bus_err)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one active edge, then settle
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // check decoded fields against bench-side slicing of the expected word
  task automatic check_fields(input string tag, input logic [7:0] w);
    logic [7:0] v;
    v = w;
    check({tag, ".instr"}, instr, v[3:0]);
    check({tag, ".r1"},    r1,    v[7:6]);
    check({tag, ".r2"},    r2,    v[5:4]);
    check({tag, ".imm4"},  imm4,  v[7:4]);
    check({tag, ".imm3"},  imm3,  v[5:3]);
    check({tag, ".imm5"},  imm5,  v[7:3]);
  endtask

  // scoreboard: each completed fetch (ir_valid rising) pops one expected word
  always @(negedge clock) begin
    if (reset_n && ir_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_load", ir, 32'hFFFF_FFFF);
      end else begin
        check("sb_ir", ir, exp_q.pop_front());
      end
    end
    prev_valid = ir_valid;
  end

  initial begin
    logic [7:0] a;
    logic [7:0] d;
    int         lat;

    reset_n    = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 8'h5A;
    mem_ack    = 1'b0;
    mem_rdata  = 8'h00;

    // reset state (fetch_req high must not raise stall)
    repeat (2) tick();
    check("rst_mem_req",  mem_req,  0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_ir",       ir,       0);
    check("rst_ir_valid", ir_valid, 0);
    check("rst_stall",    stall,    0);
    check("rst_bus_err",  bus_err,  0);
    fetch_req = 1'b0;
    reset_n   = 1'b1;
    tick();

    // single fetch, zero wait
    fetch_req  = 1'b1;
    fetch_addr = 8'h10;
    #1;
    check("t1_stall_req", stall, 1);
    tick();
    check("t1_mem_req",  mem_req,  1);
    check("t1_mem_addr", mem_addr, 8'h10);
    check("t1_valid0",   ir_valid, 0);
    fetch_req = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h54;
    exp_q.push_back(8'h54);
    tick();
    mem_ack   = 1'b0;
    mem_rdata = 8'h00;
    check("t1_ir",       ir,       8'h54);
    check("t1_valid",    ir_valid, 1);
    check("t1_instr",    instr,    4'b0100);
    check("t1_r1",       r1,       2'b01);
    check("t1_r2",       r2,       2'b01);
    check_fields("t1", 8'h54);
    check("t1_req_done", mem_req,  0);
    check("t1_stall",    stall,    0);

    // three wait cycles; a fetch_req with a new address during BUSY is ignored
    fetch_req  = 1'b1;
    fetch_addr = 8'h22;
    tick();
    fetch_addr = 8'h99;
    for (int i = 0; i < 3; i++) begin
      check("t2_mem_req",  mem_req,  1);
      check("t2_mem_addr", mem_addr, 8'h22);
      check("t2_stall",    stall,    1);
      check("t2_valid0",   ir_valid, 0);
      tick();
    end
    check("t2_mem_addr_last", mem_addr, 8'h22);
    fetch_req = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'hC9;
    exp_q.push_back(8'hC9);
    tick();
    mem_ack = 1'b0;
    check("t2_ir",    ir,       8'hC9);
    check("t2_valid", ir_valid, 1);
    check_fields("t2", 8'hC9);

    // spurious ack in IDLE
    mem_ack   = 1'b1;
    mem_rdata = 8'hFF;
    tick();
    mem_ack = 1'b0;
    check("t3_ir",      ir,       8'hC9);
    check("t3_valid",   ir_valid, 1);
    check("t3_mem_req", mem_req,  0);
    tick();
    check("t3_ir_late", ir,       8'hC9);
    check("t3_no_req",  mem_req,  0);

    // reset mid-BUSY, then a late ack
    fetch_req  = 1'b1;
    fetch_addr = 8'h33;
    tick();
    fetch_req = 1'b0;
    tick();
    check("t4_busy_req", mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t4_req_async", mem_req,  0);
    check("t4_ir",        ir,       0);
    check("t4_valid",     ir_valid, 0);
    check("t4_stall",     stall,    0);
    @(negedge clock);
    reset_n   = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    tick();
    mem_ack = 1'b0;
    check("t4_ack_ign_ir",    ir,       0);
    check("t4_ack_ign_valid", ir_valid, 0);
    check("t4_ack_ign_req",   mem_req,  0);

    // back-to-back with fetch_req held
    fetch_req  = 1'b1;
    fetch_addr = 8'h00;
    tick();
    check("t5_addr0", mem_addr, 8'h00);
    check("t5_req0",  mem_req,  1);
    fetch_addr = 8'h01;
    mem_ack    = 1'b1;
    mem_rdata  = 8'h11;
    exp_q.push_back(8'h11);
    tick();
    mem_ack = 1'b0;
    check("t5_ir0",      ir,       8'h11);
    check("t5_gap_req",  mem_req,  0);
    check("t5_gap_stall", stall,   1);
    tick();
    check("t5_addr1",   mem_addr, 8'h01);
    check("t5_req1",    mem_req,  1);
    check("t5_valid0",  ir_valid, 0);
    fetch_req = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h22;
    exp_q.push_back(8'h22);
    tick();
    mem_ack = 1'b0;
    check("t5_ir1",   ir,      8'h22);
    check("t5_done",  mem_req, 0);

    // random fetches with random latency
    for (int k = 0; k < 6; k++) begin
      a   = 8'($urandom_range(0, 255));
      d   = 8'($urandom_range(0, 255));
      lat = $urandom_range(0, 4);
      fetch_req  = 1'b1;
      fetch_addr = a;
      tick();
      fetch_req = 1'b0;
      check("rnd_addr", mem_addr, a);
      repeat (lat) begin
        tick();
        check("rnd_stall", stall,    1);
        check("rnd_wait",  ir_valid, 0);
      end
      mem_ack   = 1'b1;
      mem_rdata = d;
      exp_q.push_back(d);
      tick();
      mem_ack = 1'b0;
      check("rnd_valid", ir_valid, 1);
      check_fields("rnd", d);
    end

`ifdef FETCH_TIMEOUT_EN
    // no ack: abort after 15 BUSY cycles
    fetch_req  = 1'b1;
    fetch_addr = 8'h44;
    tick();
    fetch_req = 1'b0;
    exp_q.push_back(8'h0A);
    repeat (14) begin
      tick();
      check("to_waiting", ir_valid, 0);
      check("to_req",     mem_req,  1);
    end
    tick();
    check("to_ir",      ir,       8'h0A);
    check("to_instr",   instr,    4'b1010);
    check("to_valid",   ir_valid, 1);
    check("to_bus_err", bus_err,  1);
    check("to_req_off", mem_req,  0);
    // normal fetch afterwards; bus_err stays set
    fetch_req  = 1'b1;
    fetch_addr = 8'h45;
    tick();
    fetch_req = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 8'h64;
    exp_q.push_back(8'h64);
    tick();
    mem_ack = 1'b0;
    check("to_after_ir",  ir,      8'h64);
    check("to_sticky",    bus_err, 1);
`else
    check("no_bus_err", bus_err, 0);
`endif

    tick();
    tick();
    check("sb_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
